// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter for the 5-stage pipeline.
// Data requests have priority. When both stages keep requesting, grants
// alternate so that neither stage starves. Only one memory transaction is
// outstanding at a time. A watchdog ends a transaction with an error
// completion when memory does not answer within TIMEOUT busy cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  // fetch stage
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_address,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  output logic              if_stall,

  // data-memory stage
  input  logic              dm_request,
  input  logic              dm_we_re,
  input  logic [3:0]        dm_mask,
  input  logic [ADDR_W-1:0] dm_address,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              dm_stall,

  // memory port
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A zero-width counter is illegal, so a disabled timeout still gets one bit.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic               last_dm, last_dm_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic               mem_request_nx;
  logic               mem_we_re_nx;
  logic [3:0]         mem_mask_nx;
  logic [ADDR_W-1:0]  mem_address_nx;
  logic [DATA_W-1:0]  mem_wdata_nx;

  logic               busy;
  logic               timeout_hit;
  logic               done_ok;
  logic               done_tmo;
  logic               grant_dm;
  logic               grant_if;

  // Arbitration terms. A data request loses only when the fetch stage is
  // also waiting and the previous grant already went to data.
  always_comb begin
    busy        = (state != IDLE);
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
    done_ok     = busy && mem_valid;
    done_tmo    = busy && !mem_valid && timeout_hit;
    grant_dm    = (state == IDLE) && dm_request && (!if_request || !last_dm);
    grant_if    = (state == IDLE) && !grant_dm && if_request;
  end

  // State, arbitration history, watchdog and registered memory port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_dm     <= 1'b0;
      cnt         <= '0;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_mask    <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nx;
      last_dm     <= last_dm_nx;
      cnt         <= cnt_nx;
      mem_request <= mem_request_nx;
      mem_we_re   <= mem_we_re_nx;
      mem_mask    <= mem_mask_nx;
      mem_address <= mem_address_nx;
      mem_wdata   <= mem_wdata_nx;
    end
  end

  // Next-state logic: grants latch the winner's fields in the same edge,
  // completions (normal or timeout) drop the request and return to IDLE.
  always_comb begin
    state_nx        = state;
    last_dm_nx      = last_dm;
    cnt_nx          = cnt;
    mem_request_nx  = mem_request;
    mem_we_re_nx    = mem_we_re;
    mem_mask_nx     = mem_mask;
    mem_address_nx  = mem_address;
    mem_wdata_nx    = mem_wdata;

    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nx       = DM_BUSY;
          last_dm_nx     = 1'b1;
          cnt_nx         = '0;
          mem_request_nx = 1'b1;
          mem_we_re_nx   = dm_we_re;
          mem_mask_nx    = dm_mask;
          mem_address_nx = dm_address;
          mem_wdata_nx   = dm_wdata;
        end else if (grant_if) begin
          state_nx       = IF_BUSY;
          last_dm_nx     = 1'b0;
          cnt_nx         = '0;
          mem_request_nx = 1'b1;
          mem_we_re_nx   = 1'b0;
          mem_mask_nx    = 4'b1111;
          mem_address_nx = if_address;
          mem_wdata_nx   = '0;
        end
      end

      IF_BUSY, DM_BUSY: begin
        if (done_ok || done_tmo) begin
          state_nx       = IDLE;
          mem_request_nx = 1'b0;
        end else if (cnt != '1) begin
          // Saturation only matters with the timeout disabled.
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx       = IDLE;
        mem_request_nx = 1'b0;
      end
    endcase
  end

  // Completion outputs route to the owner of the current transaction only.
  always_comb begin
    if_valid = 1'b0;
    if_err   = 1'b0;
    if_rdata = '0;
    dm_valid = 1'b0;
    dm_err   = 1'b0;
    dm_rdata = '0;

    if (state == IF_BUSY) begin
      if_valid = done_ok || done_tmo;
      if_err   = done_tmo;
      if (done_ok) begin
        if_rdata = mem_rdata;
      end
    end

    if (state == DM_BUSY) begin
      dm_valid = done_ok || done_tmo;
      dm_err   = done_tmo;
      if (done_ok && !mem_we_re) begin
        dm_rdata = mem_rdata;
      end
    end
  end

  // Stall indications for the hazard unit.
  always_comb begin
    if_stall = if_request && !if_valid;
    dm_stall = dm_request && !dm_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_request, if_valid, if_err, if_stall;
  logic [AW-1:0] if_address;
  logic [DW-1:0] if_rdata;
  logic          dm_request, dm_we_re, dm_valid, dm_err, dm_stall;
  logic [3:0]    dm_mask;
  logic [AW-1:0] dm_address;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_request, mem_we_re, mem_valid;
  logic [3:0]    mem_mask;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_address(if_address), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err), .if_stall(if_stall),
    .dm_request(dm_request), .dm_we_re(dm_we_re), .dm_mask(dm_mask),
    .dm_address(dm_address), .dm_wdata(dm_wdata), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata), .dm_err(dm_err), .dm_stall(dm_stall),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: who owns the port (0 none, 1 fetch, 2 data),
  // how many busy cycles have elapsed unanswered, and who was granted last.
  int          m_owner;
  int          m_wait;
  bit          m_last_dm;
  bit          m_req, m_we, m_fresh, m_wd_ok;
  logic [3:0]  m_mask;
  logic [31:0] m_addr, m_wdata;

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_last_dm = 0;
    m_req = 0; m_we = 0; m_mask = 0; m_addr = 0; m_wdata = 0;
    m_fresh = 1; m_wd_ok = 1;
  endtask

  function automatic bit m_ok();
    return (m_owner != 0) && (mem_valid === 1'b1);
  endfunction

  function automatic bit m_tmo();
    return (m_owner != 0) && (mem_valid !== 1'b1) && (TO != 0) && (m_wait == int'(TO));
  endfunction

  task automatic check_all();
    bit ev, dv;
    logic [31:0] er, dr;
    ev = (m_owner == 1) && (m_ok() || m_tmo());
    dv = (m_owner == 2) && (m_ok() || m_tmo());
    er = (m_owner == 1 && m_ok()) ? mem_rdata : 32'h0;
    dr = (m_owner == 2 && m_ok() && !m_we) ? mem_rdata : 32'h0;
    chk("if_valid", if_valid, ev);
    chk("if_err",   if_err,   (m_owner == 1) && m_tmo());
    chk("if_rdata", if_rdata, er);
    chk("if_stall", if_stall, if_request && !ev);
    chk("dm_valid", dm_valid, dv);
    chk("dm_err",   dm_err,   (m_owner == 2) && m_tmo());
    chk("dm_rdata", dm_rdata, dr);
    chk("dm_stall", dm_stall, dm_request && !dv);
    chk("mem_request", mem_request, m_req);
    if (m_req || m_fresh) begin
      chk("mem_we_re",   mem_we_re,   m_we);
      chk("mem_mask",    mem_mask,    m_mask);
      chk("mem_address", mem_address, m_addr);
      if (m_wd_ok) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    bit ok, tmo;
    ok  = m_ok();
    tmo = m_tmo();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (dm_request && (!if_request || !m_last_dm)) begin
        m_owner = 2; m_last_dm = 1; m_wait = 0; m_req = 1; m_fresh = 0;
        m_we = dm_we_re; m_mask = dm_mask; m_addr = dm_address;
        m_wdata = dm_wdata; m_wd_ok = 1;
      end else if (if_request) begin
        m_owner = 1; m_last_dm = 0; m_wait = 0; m_req = 1; m_fresh = 0;
        m_we = 0; m_mask = 4'hF; m_addr = if_address; m_wd_ok = 0;
      end
    end else if (ok || tmo) begin
      m_owner = 0; m_req = 0;
    end else begin
      m_wait++;
    end
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    int          first_dv, first_if, pulses, cyc;
    bit          prev_req, found, saw_if, saw_dm;

    rst = 0; if_request = 0; if_address = 0; dm_request = 0; dm_we_re = 0;
    dm_mask = 0; dm_address = 0; dm_wdata = 0; mem_valid = 0; mem_rdata = 0;
    model_reset();

    // Reset state
    step(); step();
    chk("rst_mem_request", mem_request, 0);
    chk("rst_mem_mask", mem_mask, 0);
    rst = 1;

    // Lone fetch, memory answers one cycle after the request
    if_request = 1; if_address = 32'h100;
    settle(); chk("t1_stall_idle", if_stall, 1); adv();
    settle();
    chk("t1_addr", mem_address, 32'h100); chk("t1_we", mem_we_re, 0);
    chk("t1_mask", mem_mask, 4'hF); chk("t1_no_valid", if_valid, 0);
    chk("t1_stall_busy", if_stall, 1);
    adv();
    mem_valid = 1; mem_rdata = 32'h13;
    settle();
    chk("t1_valid", if_valid, 1); chk("t1_rdata", if_rdata, 32'h13);
    chk("t1_stall_done", if_stall, 0);
    adv();
    if_request = 0; mem_valid = 0;
    settle(); chk("t1_after", if_valid, 0); adv();

    // Both requesters after reset, held continuously
    rst = 0; model_reset(); step(); step(); rst = 1;
    dm_request = 1; dm_we_re = 0; dm_mask = 4'hF; dm_address = 32'h2000;
    if_request = 1; if_address = 32'h104; mem_valid = 1;
    prev_req = 0; first_dv = -1; first_if = -1;
    for (int c = 0; c < 8; c++) begin
      mem_rdata = $urandom;
      settle();
      if (mem_request && !prev_req) begin
        q.push_back(mem_address);
        if (mem_address == 32'h104 && first_if < 0) first_if = c;
      end
      if (dm_valid) begin
        chk("t2_dm_rdata", dm_rdata, mem_rdata);
        if (first_dv < 0) first_dv = c;
      end
      prev_req = mem_request;
      adv();
    end
    chk("t2_grants", q.size(), 4);
    while (q.size() < 4) q.push_back(32'hFFFF_FFFF);
    chk("t2_g0", q[0], 32'h2000); chk("t2_g1", q[1], 32'h104);
    chk("t2_g2", q[2], 32'h2000); chk("t2_g3", q[3], 32'h104);
    chk("t2_if_gap", first_if - first_dv, 2);
    dm_request = 0; if_request = 0; mem_valid = 0;
    step();

    // Store
    dm_request = 1; dm_we_re = 1; dm_mask = 4'b0011;
    dm_wdata = 32'hDEADBEEF; dm_address = 32'h3000;
    step();
    settle();
    chk("t3_req", mem_request, 1); chk("t3_we", mem_we_re, 1);
    chk("t3_mask", mem_mask, 4'b0011); chk("t3_addr", mem_address, 32'h3000);
    chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
    adv();
    mem_valid = 1; mem_rdata = 32'hCAFEF00D;
    settle(); chk("t3_valid", dm_valid, 1); chk("t3_rdata", dm_rdata, 0); adv();
    dm_request = 0; dm_we_re = 0; mem_valid = 0;
    step();

    // Timeout on an unanswered fetch
    if_request = 1; if_address = 32'h200;
    step();
    found = 0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      if (if_valid) begin
        chk("t4_cycle", k, TO + 1);
        chk("t4_err", if_err, 1);
        chk("t4_rdata", if_rdata, 0);
        found = 1;
        adv();
        break;
      end
      adv();
    end
    chk("t4_seen", found, 1);
    if_request = 0;
    settle(); chk("t4_req_low", mem_request, 0); adv();

    // Asynchronous reset during a data transaction
    dm_request = 1; dm_address = 32'h4000;
    step(); step();
    if_request = 1; if_address = 32'h300;
    #2; rst = 0; #1;
    model_reset();
    check_all();
    chk("t5_no_dm_valid", dm_valid, 0); chk("t5_req", mem_request, 0);
    chk("t5_addr", mem_address, 0);
    dm_request = 0;
    step(); rst = 1;
    step();
    mem_valid = 1; mem_rdata = 32'h5555;
    settle();
    chk("t5_if_addr", mem_address, 32'h300); chk("t5_if_req", mem_request, 1);
    adv();
    if_request = 0; mem_valid = 0;
    step();

    // mem_valid while idle, then a fetch withdrawn mid-transaction
    mem_valid = 1; mem_rdata = $urandom;
    settle(); chk("t6_idle_if", if_valid, 0); chk("t6_idle_dm", dm_valid, 0); adv();
    mem_valid = 0; if_request = 1; if_address = 32'h500;
    step();
    if_request = 0;
    step();
    mem_valid = 1; mem_rdata = 32'h77;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      if (if_valid) pulses++;
      adv();
      mem_valid = 0;
    end
    chk("t6_pulses", pulses, 1);

    // Random traffic against the model
    saw_if = 0; saw_dm = 0;
    for (cyc = 0; cyc < 1500; cyc++) begin
      settle();
      saw_if = if_valid; saw_dm = dm_valid;
      adv();
      if (!rst) rst = 1;
      else if ($urandom_range(0, 300) == 0) begin rst = 0; model_reset(); end
      if (!if_request) begin
        if ($urandom_range(0, 2) == 0) begin if_request = 1; if_address = $urandom; end
      end else if (saw_if || $urandom_range(0, 40) == 0) if_request = 0;
      if (!dm_request) begin
        if ($urandom_range(0, 2) == 0) begin
          dm_request = 1; dm_we_re = 1'($urandom); dm_mask = 4'($urandom);
          dm_address = $urandom; dm_wdata = $urandom;
        end
      end else if (saw_dm || $urandom_range(0, 40) == 0) dm_request = 0;
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
